// File: rtl/spi_cmd_decoder_if.sv
// Byte-level link between the SPI byte receiver and the command decoder.
// The receiver side is the master; the decoder is the slave.
interface spi_cmd_decoder_if;
    logic       sel_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [3:0] gpio_out;
    logic       frame_err;

    modport master (
        output sel_active,
        output rx_valid,
        output rx_byte,
        input  tx_byte,
        input  tx_load,
        input  gpio_out,
        input  frame_err
    );

    modport slave (
        input  sel_active,
        input  rx_valid,
        input  rx_byte,
        output tx_byte,
        output tx_load,
        output gpio_out,
        output frame_err
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Framed command parser and 4-entry register file behind the SPI byte receiver.
// First byte of a frame is the command; following bytes write or read registers
// with an auto-incrementing 2-bit address. reg3 is a read-only status byte.
module spi_cmd_decoder (
    input  logic               ico_clk,
    input  logic               rst,
    spi_cmd_decoder_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWrite,
        StRead,
        StDiscard
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] regs_q [3];
    logic [7:0] regs_d [3];
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [3:0] frame_cnt_q, frame_cnt_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_load_q, tx_load_d;

    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       cmd_ok;

    assign cmd_ok = (bus.rx_byte[6:2] == 5'b00000);

    // Read address: the command byte supplies it directly, later bytes use the counter.
    always_comb begin
        rd_addr = (state_q == StCmd) ? bus.rx_byte[1:0] : addr_q;
        case (rd_addr)
            2'd0:    rd_data = regs_q[0];
            2'd1:    rd_data = regs_q[1];
            2'd2:    rd_data = regs_q[2];
            default: rd_data = {err_cnt_q, frame_cnt_q};
        endcase
    end

    // Next-state, register file and reply byte.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = frame_err_q;
        tx_byte_d   = tx_byte_q;
        tx_load_d   = 1'b0;

        if (state_q != StIdle && !bus.sel_active) begin
            // Frame ended; any byte arriving now is dropped.
            state_d = StIdle;
            if (state_q != StCmd) begin
                frame_cnt_d = frame_cnt_q + 4'd1;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.sel_active) begin
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    if (bus.rx_valid) begin
                        // Every accepted byte gets a reply so the receiver never
                        // shifts out stale data.
                        tx_load_d = 1'b1;
                        if (!cmd_ok) begin
                            state_d     = StDiscard;
                            tx_byte_d   = 8'hEE;
                            frame_err_d = 1'b1;
                            if (err_cnt_q != 4'hF) begin
                                err_cnt_d = err_cnt_q + 4'd1;
                            end
                        end else if (bus.rx_byte[7]) begin
                            state_d   = StWrite;
                            addr_d    = bus.rx_byte[1:0];
                            tx_byte_d = 8'h00;
                        end else begin
                            state_d   = StRead;
                            tx_byte_d = rd_data;
                            addr_d    = bus.rx_byte[1:0] + 2'd1;
                        end
                    end
                end
                StWrite: begin
                    if (bus.rx_valid) begin
                        case (addr_q)
                            2'd0:    regs_d[0] = bus.rx_byte;
                            2'd1:    regs_d[1] = bus.rx_byte;
                            2'd2:    regs_d[2] = bus.rx_byte;
                            default: ;  // status register is read-only
                        endcase
                        addr_d    = addr_q + 2'd1;
                        tx_byte_d = 8'h00;
                        tx_load_d = 1'b1;
                    end
                end
                StRead: begin
                    if (bus.rx_valid) begin
                        tx_byte_d = rd_data;
                        tx_load_d = 1'b1;
                        addr_d    = addr_q + 2'd1;
                    end
                end
                StDiscard: begin
                    if (bus.rx_valid) begin
                        tx_byte_d = 8'hEE;
                        tx_load_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and register update with synchronous reset.
    always_ff @(posedge ico_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= 2'd0;
            regs_q[0]   <= 8'h00;
            regs_q[1]   <= 8'h00;
            regs_q[2]   <= 8'h00;
            err_cnt_q   <= 4'd0;
            frame_cnt_q <= 4'd0;
            frame_err_q <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
            tx_byte_q   <= tx_byte_d;
            tx_load_q   <= tx_load_d;
        end
    end

    assign bus.tx_byte   = tx_byte_q;
    assign bus.tx_load   = tx_load_q;
    assign bus.gpio_out  = regs_q[0][3:0];
    assign bus.frame_err = frame_err_q;

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Command/register stage directly downstream of the Pi-facing SPI byte receiver on the icoboard. Consumes the stream of completed receive bytes and the frame-select level, parses a framed command protocol (command byte then data bytes), and maintains a 4-entry 8-bit register file. It returns read data to the receiver as the next byte to shift out, and drives the GPIO nibble from register 0.

## Interface
Parameters:
- None. Register count fixed at 4; widths fixed at 8 bits.

Ports:
- ico_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sel_active  in  1  frame-active level from receiver, already synchronised; high = SEL asserted.
- rx_valid  in  1  one-cycle pulse: rx_byte holds a completed byte.
- rx_byte  in  8  received byte, MSB first as shifted in; valid only with rx_valid.
- tx_byte  out  8  byte the receiver shifts out during the next byte slot.
- tx_load  out  1  one-cycle pulse: receiver latches tx_byte.
- gpio_out  out  4  reg0[3:0], drives gpio4/17/27/22 (bit 0..3).
- frame_err  out  1  sticky: high once any malformed command is seen; cleared only by rst.

## Operation
- Command byte (first byte of a frame): bit7 = W (1 write, 0 read); bits[6:2] must be 5'b00000; bits[1:0] = start address.
- Register map: reg0 GPIO (rw), reg1 and reg2 scratch (rw), reg3 status (ro) = {err_cnt[3:0], frame_cnt[3:0]}. Writes to address 3 are accepted in sequence but discarded.
- States: IDLE, CMD, WRITE, READ, DISCARD.
- IDLE: wait for sel_active high -> CMD. rx_valid ignored.
- CMD: on rx_valid, decode. Valid write -> WRITE, addr <= bits[1:0]. Valid read -> READ, load reg[addr] into tx_byte, pulse tx_load, addr <= addr+1. Reserved bits nonzero -> DISCARD, tx_byte <= 8'hEE, pulse tx_load, err_cnt += 1 (saturate at 15), frame_err <= 1.
- WRITE: each rx_valid writes rx_byte to reg[addr] (unless addr==3); addr <= addr+1, wrapping 3 -> 0. tx_byte <= 8'h00 with tx_load pulse per byte.
- READ: each rx_valid (the dummy byte the Pi clocks in) loads reg[addr] into tx_byte, pulses tx_load, addr <= addr+1 with wrap. Incoming data ignored.
- DISCARD: every rx_valid reloads 8'hEE with a tx_load pulse. No register writes.
- sel_active low in any non-IDLE state -> IDLE next cycle. frame_cnt += 1 (mod 16) if the command byte had been accepted (state was WRITE, READ or DISCARD). A frame ending in CMD is not counted.
- Address counter is 2 bits; wrap is natural modulo-4.

## Timing
- Reset values: tx_byte 8'h00, tx_load 0, gpio_out 4'h0, frame_err 0, all regs 0, err_cnt 0, frame_cnt 0, state IDLE.
- rx_valid at edge N: register write visible at N+1 (gpio_out changes at N+1); tx_byte valid and tx_load high during cycle N+1 only.
- Status reg3 read returns counter values as of edge N, before any update at N.
- rx_valid coincident with sel_active low: byte ignored, no write, no tx_load; the state goes to IDLE.
- rx_valid back-to-back on consecutive cycles is legal and each byte is processed.
- rst mid-frame: all state and regs return to reset values at the next edge, regardless of sel_active. With sel_active still high after reset, the FSM enters CMD and treats the next byte as a command.
- tx_load never asserts in IDLE.

## Test plan
- Write frame 0x80,0x0A -> gpio_out 4'hA one cycle after the second rx_valid; tx_load pulses twice, with tx_byte 0x00 on the second.
- Burst write 0x82,0x11,0x22,0x33,0x44 -> reg2=0x11, reg3 unchanged, reg0=0x33, reg1=0x44 (wrap verified).
- Read frame 0x01 followed by 3 dummy bytes -> tx_byte sequence reg1, reg2, reg3, reg0, each with its own tx_load pulse.
- Bad command 0x7C -> tx_byte 0xEE on every byte; frame_err=1; no register change. Reading reg3 in the next frame gives err_cnt=1 and frame_cnt=1 in the upper and lower nibbles.
- sel_active drops between command and data, then a new frame 0x80,0x05 -> first byte of the new frame is decoded as a command; gpio_out=4'h5.
- rst asserted mid burst write -> all outputs return to reset values next cycle; the following frame decodes normally.
